// File: rtl/sync_pkg.sv
// sync_pkg: shared constants and helpers for the sync_edge_detect input
// conditioner.
//   EDGE_PRESS / EDGE_RELEASE / EDGE_BOTH : edge-mode selectors
//   cnt_width(n)   : bits needed for a counter spanning 0..n-1 (min 1)
//   edge_qual(m,l) : does a flip to new level l qualify under mode m
package sync_pkg;

  localparam int EDGE_PRESS   = 0;
  localparam int EDGE_RELEASE = 1;
  localparam int EDGE_BOTH    = 2;

  // clog2-style width; never returns 0 so a D=1 counter still has a
  // legal (constant-zero) register.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic logic edge_qual(input int mode, input logic new_lvl);
    logic q;
    case (mode)
      EDGE_PRESS:   q = new_lvl;
      EDGE_RELEASE: q = ~new_lvl;
      default:      q = 1'b1;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/sync_edge_chan.sv
// sync_edge_chan: one conditioner channel.
//   synchroniser (SYNC_STAGES flops) -> polarity normalise -> debounce
//   -> registered level + one-cycle qualified edge pulse.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : pulse enable (filtering runs regardless)
//   signal     : raw asynchronous input
//   level      : debounced active-high state
//   pulse      : one-cycle strobe on a qualified level flip
module sync_edge_chan
  import sync_pkg::*;
#(
  parameter bit ACTIVE          = 1'b0,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_MODE       = EDGE_PRESS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic signal,
  output logic level,
  output logic pulse
);

  localparam int D  = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 1;
  localparam int CW = cnt_width(D);
  localparam logic [CW-1:0] CNT_MAX = CW'(D - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   act;
  logic                   flip;

  // Chain resets to the inactive pin level so reset release never looks
  // like an edge unless the pin really is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{~ACTIVE}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], signal};
  end

  assign act  = (sync_q[SYNC_STAGES-1] == ACTIVE);
  assign flip = (act != level) && (cnt == CNT_MAX);

  // Counter tracks consecutive cycles that act disagrees with level; any
  // agreeing cycle restarts the count, so short glitches are swallowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (act == level) begin
      cnt   <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt   <= '0;
      level <= act;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

  // Registered alongside the level flip; dropped (not deferred) when en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pulse <= 1'b0;
    else        pulse <= en & flip & edge_qual(EDGE_MODE, act);
  end

endmodule

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-channel synchronise/debounce/edge-detect block
// for asynchronous board inputs.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : pulse enable
//   signal     : [CHANNELS] raw asynchronous inputs
//   level      : [CHANNELS] debounced active-high state
//   pulse      : [CHANNELS] one-cycle qualified edge strobes
//   any_pulse  : OR of pulse (combinational)
module sync_edge_detect
  import sync_pkg::*;
#(
  parameter int                  CHANNELS        = 4,
  parameter int                  SYNC_STAGES     = 2,
  parameter int                  DEBOUNCE_CYCLES = 0,
  parameter logic [CHANNELS-1:0] ACTIVE_MASK     = '0,
  parameter int                  EDGE_MODE       = EDGE_PRESS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CHANNELS-1:0] signal,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pulse,
  output logic                any_pulse
);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    sync_edge_chan #(
      .ACTIVE          (ACTIVE_MASK[gi]),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EDGE_MODE       (EDGE_MODE)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .signal (signal[gi]),
      .level  (level[gi]),
      .pulse  (pulse[gi])
    );
  end

  assign any_pulse = |pulse;

endmodule

// File: tb/tb_sync_edge_detect.sv
// tb_sync_edge_detect: two configurations driven side by side, each checked
// every cycle against a history-based reference model (a flip happens when
// the last D synchronised samples all disagree with the current level).
module tb_sync_edge_detect;

  localparam int N = 4;
  // instance 0: defaults; instance 1: deeper sync, debounce, both edges
  localparam int              S0 = 2, DB0 = 0, E0 = 0;
  localparam logic [N-1:0]    M0 = 4'b0000;
  localparam int              S1 = 3, DB1 = 4, E1 = 2;
  localparam logic [N-1:0]    M1 = 4'b0100;
  localparam int              HL = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [N-1:0] sig0, sig1;
  logic [N-1:0] level0, pulse0, level1, pulse1;
  logic         any0, any1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sync_edge_detect #(.CHANNELS(N), .SYNC_STAGES(S0), .DEBOUNCE_CYCLES(DB0),
                     .ACTIVE_MASK(M0), .EDGE_MODE(E0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .signal(sig0),
    .level(level0), .pulse(pulse0), .any_pulse(any0));

  sync_edge_detect #(.CHANNELS(N), .SYNC_STAGES(S1), .DEBOUNCE_CYCLES(DB1),
                     .ACTIVE_MASK(M1), .EDGE_MODE(E1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .signal(sig1),
    .level(level1), .pulse(pulse1), .any_pulse(any1));

  // ---------------- reference model ----------------
  logic [N-1:0] raw_h [2][HL];   // raw pins captured at past edges, [0] newest
  logic [N-1:0] act_h [2][HL];   // active samples seen by the filter, [0] newest
  logic [N-1:0] lvl_m [2];
  logic [N-1:0] pls_m [2];

  task automatic model_reset(input int k);
    logic [N-1:0] msk;
    msk = (k == 0) ? M0 : M1;
    for (int j = 0; j < HL; j++) begin
      raw_h[k][j] = ~msk;
      act_h[k][j] = '0;
    end
    lvl_m[k] = '0;
    pls_m[k] = '0;
  endtask

  task automatic model_step(input int k, input logic [N-1:0] sig);
    int s, d, md;
    logic [N-1:0] msk, nl, pl;
    logic all_diff;
    s   = (k == 0) ? S0 : S1;
    d   = (k == 0) ? DB0 : DB1;
    if (d < 1) d = 1;
    md  = (k == 0) ? E0 : E1;
    msk = (k == 0) ? M0 : M1;
    for (int j = HL - 1; j > 0; j--) act_h[k][j] = act_h[k][j-1];
    // pin value captured s edges ago reaches the filter now
    act_h[k][0] = ~(raw_h[k][s-1] ^ msk);
    nl = lvl_m[k];
    pl = '0;
    for (int c = 0; c < N; c++) begin
      all_diff = 1'b1;
      for (int j = 0; j < d; j++)
        if (act_h[k][j][c] == lvl_m[k][c]) all_diff = 1'b0;
      if (all_diff) begin
        nl[c] = ~lvl_m[k][c];
        pl[c] = en && ((md == 2) || (md == 0 && nl[c]) || (md == 1 && !nl[c]));
      end
    end
    lvl_m[k] = nl;
    pls_m[k] = pl;
    for (int j = HL - 1; j > 0; j--) raw_h[k][j] = raw_h[k][j-1];
    raw_h[k][0] = sig;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, sig0);
      model_step(1, sig1);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("level0", 32'(level0), 32'(lvl_m[0]));
    chk("pulse0", 32'(pulse0), 32'(pls_m[0]));
    chk("any0",   32'(any0),   32'(|pls_m[0]));
    chk("level1", 32'(level1), 32'(lvl_m[1]));
    chk("pulse1", 32'(pulse1), 32'(pls_m[1]));
    chk("any1",   32'(any1),   32'(|pls_m[1]));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    rst_n = 1'b0;
    en    = 1'b1;
    sig0  = ~M0;
    sig1  = ~M1;
    repeat (3) @(negedge clk);
    chk("rst_level0", 32'(level0), 32'h0);
    chk("rst_pulse0", 32'(pulse0), 32'h0);
    chk("rst_level1", 32'(level1), 32'h0);
    chk("rst_pulse1", 32'(pulse1), 32'h0);
    rst_n = 1'b1;
    step(4);

    // inactive inputs after reset: nothing happens
    chk("idle_level0", 32'(level0), 32'h0);

    // press ch0 (active-low) on instance 0: exactly one pulse, level 0001
    sig0[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_all();
      if (pulse0[0]) cnt++;
    end
    chk("s1_npulse", 32'(cnt), 32'd1);
    chk("s1_level",  32'(level0), 32'h1);
    sig0[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_all();
      if (pulse0[0]) cnt++;
    end
    chk("s1_norel", 32'(cnt), 32'd0);

    // debounce: 3-cycle glitch on instance 1 ch1 is rejected, 4 accepted
    sig1[1] = 1'b0; step(3);
    sig1[1] = 1'b1; step(10);
    chk("glitch_level1", 32'(level1[1]), 32'h0);
    sig1[1] = 1'b0; step(4);
    sig1[1] = 1'b1; step(12);

    // active-high ch2 on instance 1, both-edge mode
    sig1[2] = 1'b1; step(20);
    chk("ch2_level_hi", 32'(level1[2]), 32'h1);
    sig1[2] = 1'b0; step(20);
    chk("ch2_level_lo", 32'(level1[2]), 32'h0);

    // en low across a press: level follows, pulse dropped for good
    en = 1'b0; sig0[3] = 1'b0; step(6);
    chk("en_level3", 32'(level0[3]), 32'h1);
    en = 1'b1; step(4);
    sig0[3] = 1'b1; step(6);

    // simultaneous press on ch0 and ch3
    sig0[0] = 1'b0; sig0[3] = 1'b0;
    step(6);
    sig0[0] = 1'b1; sig0[3] = 1'b1;
    step(6);

    // reset one cycle before the expected pulse, then hold ch0 active
    sig0[0] = 1'b0;
    step(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pulse0", 32'(pulse0), 32'h0);
    chk("mid_rst_level0", 32'(level0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(6);
    chk("fresh_press_lvl", 32'(level0[0]), 32'h1);
    sig0[0] = 1'b1;
    step(6);

    // randomized traffic with occasional resets and en drops
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 7) == 0) sig0[c] = ~sig0[c];
        if ($urandom_range(0, 5) == 0) sig1[c] = ~sig1[c];
      end
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
